// File: rtl/sd_cic_decim_pkg.sv
// Shared constants for the sigma-delta ADC front end: PCM width, default CIC
// geometry and the accumulator width rule.
package sd_cic_decim_pkg;

  localparam int ADC_W          = 16;
  localparam int DECIM_LOG2_DEF = 6;
  localparam int CIC_ORDER_DEF  = 3;

  // Full-scale gain is DECIM^ORDER, so this width holds it without loss.
  function automatic int cic_acc_w(input int order, input int dlog2);
    return order * dlog2 + 1;
  endfunction

endpackage

// File: rtl/sd_cic_decim_if.sv
// Channel-side bundle of the decimator: modulator bit, bit enable, channel
// enable and the PCM sample/strobe/saturation outputs.
interface sd_cic_decim_if
  import sd_cic_decim_pkg::*;
#(
  parameter int OUT_W = ADC_W
);

  logic             sd_in;
  logic             sd_ce;
  logic             en;
  logic [OUT_W-1:0] sample_out;
  logic             sample_valid;
  logic             sat;

  modport master (
    output sd_in, sd_ce, en,
    input  sample_out, sample_valid, sat
  );

  modport slave (
    input  sd_in, sd_ce, en,
    output sample_out, sample_valid, sat
  );

endinterface

// File: rtl/sd_cic_decim_sync.sv
// Two-flop synchronizer for a single asynchronous pad bit.
module sd_cic_decim_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/sd_cic_decim.sv
// CIC decimator turning one sigma-delta bitstream into unsigned PCM samples,
// with warm-up suppression and sticky full-scale saturation flag.
module sd_cic_decim
  import sd_cic_decim_pkg::*;
#(
  parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
  parameter int ORDER      = CIC_ORDER_DEF,
  parameter int OUT_W      = ADC_W
) (
  input  logic          clk64M,
  input  logic          reset,
  sd_cic_decim_if.slave bus
);

  localparam int ACC_W  = cic_acc_w(ORDER, DECIM_LOG2);
  localparam int WARM_W = $clog2(ORDER + 1);

  logic                  sd_bit;
  logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
  logic                  dstb;

  sd_cic_decim_sync u_sync (
    .clk (clk64M),
    .rst (reset),
    .d   (bus.sd_in),
    .q   (sd_bit)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.en) begin
      cnt_d = '0;
    end else if (bus.sd_ce) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign dstb = bus.en && bus.sd_ce && (cnt_q == '1);

  genvar gi;

  // Integrator cascade; modulo wrap is harmless because the combs undo it.
  for (gi = 0; gi < ORDER; gi++) begin : g_integ
    logic [ACC_W-1:0] acc_q, acc_d, addend;

    if (gi == 0) begin : g_first
      assign addend = {{(ACC_W-1){1'b0}}, sd_bit};
    end else begin : g_next
      assign addend = g_integ[gi-1].acc_q;
    end

    always_comb begin
      acc_d = acc_q;
      if (!bus.en) begin
        acc_d = '0;
      end else if (bus.sd_ce) begin
        acc_d = acc_q + addend;
      end
    end

    always_ff @(posedge clk64M or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
  end

  // Comb pipeline: a token enters on dstb and moves one stage per clock,
  // independent of sd_ce, so an in-flight sample always drains.
  for (gi = 0; gi < ORDER; gi++) begin : g_comb
    logic [ACC_W-1:0] in_q, in_d, dly_q, dly_d, diff, load_val;
    logic             v_q, v_d, load;

    if (gi == 0) begin : g_first
      assign load     = dstb;
      assign load_val = g_integ[ORDER-1].acc_q;
    end else begin : g_next
      assign load     = g_comb[gi-1].v_q;
      assign load_val = g_comb[gi-1].diff;
    end

    assign diff = in_q - dly_q;

    always_comb begin
      in_d  = in_q;
      dly_d = dly_q;
      v_d   = load;
      if (load) begin
        in_d = load_val;
      end
      if (v_q) begin
        dly_d = in_q;
      end
      if (!bus.en) begin
        in_d  = '0;
        dly_d = '0;
        v_d   = 1'b0;
      end
    end

    always_ff @(posedge clk64M or posedge reset) begin
      if (reset) begin
        in_q  <= '0;
        dly_q <= '0;
        v_q   <= 1'b0;
      end else begin
        in_q  <= in_d;
        dly_q <= dly_d;
        v_q   <= v_d;
      end
    end
  end

  logic [ACC_W-1:0] comb_r;
  logic             comb_fire, clip, unused_lsbs;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              valid_q, valid_d, sat_q, sat_d;

  assign comb_r      = g_comb[ORDER-1].diff;
  assign comb_fire   = g_comb[ORDER-1].v_q;
  // Only exact full scale (2^(ACC_W-1)) reaches the top bit.
  assign clip        = comb_r[ACC_W-1];
  assign unused_lsbs = ^comb_r[ACC_W-OUT_W-2:0];

  always_comb begin
    warm_d   = warm_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    sat_d    = sat_q;
    if (comb_fire) begin
      if (warm_q != WARM_W'(ORDER)) begin
        warm_d = warm_q + 1'b1;
      end else begin
        valid_d  = 1'b1;
        sample_d = clip ? '1 : comb_r[ACC_W-2 -: OUT_W];
        if (clip) begin
          sat_d = 1'b1;
        end
      end
    end
    if (!bus.en) begin
      warm_d   = '0;
      sample_d = '0;
      valid_d  = 1'b0;
      sat_d    = 1'b0;
    end
  end

  always_ff @(posedge clk64M or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      warm_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.sat          = sat_q;

endmodule

// File: tb/tb_sd_cic_decim.sv
// Directed bench for sd_cic_decim: constant, 50%, 25% density, step, sd_ce
// gating, mid-pipeline reset and en-low restart.
module tb_sd_cic_decim;
  import sd_cic_decim_pkg::*;

  logic clk64M = 1'b0;
  logic reset  = 1'b1;

  always #5 clk64M = ~clk64M;

  sd_cic_decim_if #(.OUT_W(ADC_W)) bus ();

  sd_cic_decim dut (
    .clk64M (clk64M),
    .reset  (reset),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc, pc, mode, n_strobe, prev_cyc, skip, exp_first, exp_gap;
  bit          chk_val, mono;
  logic [15:0] exp_val, last_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pattern modes: 0 zeros, 1 ones, 2 alternating, 3 one-in-four, 4 sd_ce 50% with data toggling per valid bit.
  task automatic drive();
    logic [31:0] p;
    p = pc;
    case (mode)
      0:       begin bus.sd_in = 1'b0;              bus.sd_ce = 1'b1; end
      1:       begin bus.sd_in = 1'b1;              bus.sd_ce = 1'b1; end
      2:       begin bus.sd_in = p[0];              bus.sd_ce = 1'b1; end
      3:       begin bus.sd_in = (p[1:0] == 2'b00); bus.sd_ce = 1'b1; end
      default: begin bus.sd_in = p[1];              bus.sd_ce = p[0]; end
    endcase
    pc++;
  endtask

  task automatic start_phase(input int first);
    cyc       = 0;
    n_strobe  = 0;
    prev_cyc  = -1;
    exp_first = first;
  endtask

  task automatic tick();
    drive();
    @(posedge clk64M);
    #1;
    cyc++;
    if (bus.sample_valid) begin
      $display("strobe %0d mode=%0d cyc=%0d sample=0x%04h sat=%0b",
               n_strobe, mode, cyc, bus.sample_out, bus.sat);
      if (n_strobe == 0 && exp_first > 0) check_eq("first_strobe_cycle", cyc, exp_first);
      if (mono) check_eq("monotonic", {31'd0, bus.sample_out >= last_val}, 32'd1);
      if (skip > 0) begin
        skip--;
      end else begin
        if (chk_val) check_eq("sample_value", {16'd0, bus.sample_out}, {16'd0, exp_val});
        if (prev_cyc >= 0) check_eq("strobe_gap", cyc - prev_cyc, exp_gap);
      end
      prev_cyc = cyc;
      last_val = bus.sample_out;
      n_strobe++;
    end
  endtask

  task automatic wait_strobe(input int max_cyc, input string tag);
    bit seen;
    int k;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < max_cyc) begin
      tick();
      seen = bus.sample_valid;
      k++;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int settle_at;
    bus.sd_in = 1'b0;
    bus.sd_ce = 1'b1;
    bus.en    = 1'b1;
    mode = 0; pc = 0; chk_val = 1'b0; mono = 1'b0; skip = 0;
    exp_gap = 64; exp_val = 16'h0000; last_val = 16'h0000;
    start_phase(0);

    // Reset state
    repeat (3) @(posedge clk64M);
    #1;
    check_eq("reset_sample_out", {16'd0, bus.sample_out}, 32'd0);
    check_eq("reset_valid", {31'd0, bus.sample_valid}, 32'd0);
    check_eq("reset_sat", {31'd0, bus.sat}, 32'd0);

    // All zeros: first strobe at the 4th decimation result
    reset = 1'b0;
    start_phase(259);
    chk_val = 1'b1; exp_val = 16'h0000;
    repeat (3) wait_strobe(300, "zeros");
    check_eq("zeros_sat", {31'd0, bus.sat}, 32'd0);

    // Step to all ones right after a strobe
    mode = 1; chk_val = 1'b0; mono = 1'b1; settle_at = 0;
    for (int s = 1; s <= 6; s++) begin
      wait_strobe(100, "step");
      if (settle_at == 0 && bus.sample_out == 16'hFFFF) settle_at = s;
    end
    check_eq("step_settle_within_4", {31'd0, settle_at >= 1 && settle_at <= 4}, 32'd1);
    mono = 1'b0; chk_val = 1'b1; exp_val = 16'hFFFF;
    repeat (2) wait_strobe(100, "ones");
    check_eq("ones_sat", {31'd0, bus.sat}, 32'd1);

    // Asynchronous reset while a sample sits in the comb pipeline
    repeat (62) tick();
    reset = 1'b1;
    #1;
    check_eq("midpipe_reset_sample_out", {16'd0, bus.sample_out}, 32'd0);
    check_eq("midpipe_reset_sat", {31'd0, bus.sat}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk64M);
      #1;
      check_eq("midpipe_reset_valid", {31'd0, bus.sample_valid}, 32'd0);
    end

    // Alternating data: exact half scale from the first strobe
    mode = 2; exp_val = 16'h8000; exp_gap = 64; skip = 0;
    reset = 1'b0;
    start_phase(259);
    repeat (4) wait_strobe(300, "alt");

    // One-in-four density after a run-time switch
    mode = 3; skip = 4; exp_val = 16'h4000;
    repeat (7) wait_strobe(100, "quarter");

    // en low clears on the following edge, restart warm-up on release
    bus.en = 1'b0;
    @(posedge clk64M);
    #1;
    check_eq("en_low_sample_out", {16'd0, bus.sample_out}, 32'd0);
    check_eq("en_low_valid", {31'd0, bus.sample_valid}, 32'd0);
    @(posedge clk64M);
    #1;
    bus.en = 1'b1;
    start_phase(259);
    skip = 0;
    repeat (3) wait_strobe(300, "en_release");
    check_eq("en_release_sat", {31'd0, bus.sat}, 32'd0);

    // sd_ce at 50%: strobe period doubles, value unchanged
    mode = 4; skip = 4; exp_gap = 128; exp_val = 16'h8000;
    repeat (7) wait_strobe(200, "ce_half");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
